cpu_run_ctrl: RTL and testbench
===============================

CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

Interface
REQ-001 SHALL have parameter PC_W, default 32: width of the CPU program counter.
REQ-002 SHALL have parameter CNT_W, default 16: width of the burst and retired-instruction counters.
REQ-003 SHALL have parameter NUM_BP, default 2: number of PC breakpoint slots; IDX_W = max(1, clog2(NUM_BP)).
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-low; sampled on rising clk.
REQ-006 runCPU  in  1  request free-run.
REQ-007 step_req  in  1  request execution of exactly one instruction.
REQ-008 burst_req  in  1  request a run of cnt_val instructions.
REQ-009 cnt_val  in  CNT_W  burst instruction count, sampled with burst_req.
REQ-010 halt_req  in  1  request stop.
REQ-011 instr_done  in  1  CPU retired one instruction this cycle.
REQ-012 pc  in  PC_W  PC of the next instruction, valid when instr_done=1.
REQ-013 bp_wr  in  1  write breakpoint slot bp_idx with bp_addr and bp_en.
REQ-014 bp_idx / bp_addr / bp_en  in  IDX_W / PC_W / 1  breakpoint write data.
REQ-015 cpu_en  out  1  CPU advance enable.
REQ-016 state  out  2  HALT=0, RUN=1, STEP=2, BURST=3.
REQ-017 halted_bp  out  1  last halt was caused by a breakpoint.
REQ-018 bp_hit_idx  out  IDX_W  slot that caused the last breakpoint halt.
REQ-019 retired  out  CNT_W  count of instructions retired while cpu_en=1.

Function
REQ-020 cpu_en SHALL be combinational: 1 whenever state != HALT, 0 otherwise; all other outputs SHALL be registered.
REQ-021 A request sampled at edge N SHALL update state at edge N, so cpu_en reflects it in the cycle after the request was presented (one-cycle latency).
REQ-022 In HALT, the priority SHALL be runCPU > step_req > burst_req; burst_req with cnt_val=0 SHALL be ignored; halt_req SHALL have no effect.
REQ-023 Leaving HALT SHALL clear halted_bp; burst_req SHALL load the remaining counter with cnt_val.
REQ-024 In RUN, STEP or BURST, halt_req SHALL move to HALT at the next edge and SHALL take priority over every other event in the same cycle; runCPU, step_req and burst_req SHALL be ignored.
REQ-025 STEP SHALL move to HALT on the first instr_done; breakpoints SHALL be ignored in STEP.
REQ-026 BURST SHALL decrement the remaining counter on each instr_done and SHALL move to HALT on the instr_done where remaining=1.
REQ-027 Breakpoint match: instr_done=1 AND slot enabled AND pc equals slot address; in RUN or BURST a match SHALL move to HALT, set halted_bp=1 and load bp_hit_idx; when several slots match, the lowest index SHALL win.
REQ-028 If a breakpoint match and a burst count expiry coincide, the block SHALL halt once, with halted_bp=1.
REQ-029 retired SHALL increment on each instr_done while cpu_en=1, wrapping from all-ones to 0; instr_done while in HALT SHALL be ignored.
REQ-030 bp_wr SHALL be accepted in any state; the new slot contents SHALL apply to matches from the next cycle; bp_idx >= NUM_BP SHALL be ignored.

Reset
REQ-031 With reset=0 at an edge, the block SHALL set state=HALT, cpu_en=0, halted_bp=0, bp_hit_idx=0, retired=0, remaining=0, and every breakpoint slot to disabled with address 0, in any state, including mid-burst.
REQ-032 While reset=0, all requests and bp_wr SHALL be ignored.

Verification
REQ-033 Reset, then runCPU pulse -> state=RUN and cpu_en=1 one cycle later; halt_req -> state=HALT and cpu_en=0 at the next cycle.
REQ-034 step_req, then three instr_done pulses -> exactly one instruction is counted (retired=1) and state=HALT after the first.
REQ-035 burst_req with cnt_val=5, instr_done every cycle -> HALT after the fifth pulse, retired=5, halted_bp=0; burst_req with cnt_val=0 -> state stays HALT.
REQ-036 Slot 0 = 0x40 and slot 1 = 0x40, both enabled; RUN with instr_done and pc=0x40 -> HALT, halted_bp=1, bp_hit_idx=0; the same in STEP -> halted_bp=0.
REQ-037 burst_req with cnt_val=4, then reset=0 after two instr_done pulses -> HALT, retired=0, slots disabled; runCPU held through reset is ignored.
REQ-038 runCPU and step_req in the same cycle from HALT -> state=RUN; halt_req and an instr_done at breakpoint pc in the same cycle -> HALT with halted_bp=0.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/step/burst controller for a CPU core with PC breakpoints.
// Selects whether the CPU may advance (cpu_en), counts the instructions it
// retires while enabled, and stops it on request, on step/burst completion,
// or when the PC of the next instruction hits an enabled breakpoint slot.
//
// Request semantics: runCPU, step_req, burst_req and halt_req are level
// samples taken on each rising clk edge. There is no acknowledge. A request
// takes effect at the edge that samples it. It is ignored if it does not
// apply to the current state, so the requester may simply hold it for one
// cycle. instr_done and pc come from the CPU and are qualified only by
// instr_done.
module cpu_run_ctrl #(
    parameter int PC_W   = 32,
    parameter int CNT_W  = 16,
    parameter int NUM_BP = 2,
    localparam int IDX_W = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             runCPU,
    input  logic             step_req,
    input  logic             burst_req,
    input  logic [CNT_W-1:0] cnt_val,
    input  logic             halt_req,
    input  logic             instr_done,
    input  logic [PC_W-1:0]  pc,
    input  logic             bp_wr,
    input  logic [IDX_W-1:0] bp_idx,
    input  logic [PC_W-1:0]  bp_addr,
    input  logic             bp_en,
    output logic             cpu_en,
    output logic [1:0]       state,
    output logic             halted_bp,
    output logic [IDX_W-1:0] bp_hit_idx,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [1:0] {
        ST_HALT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STEP  = 2'd2,
        ST_BURST = 2'd3
    } run_state_e;

    run_state_e       state_q, state_d;
    logic             halted_bp_q, halted_bp_d;
    logic [IDX_W-1:0] bp_hit_idx_q, bp_hit_idx_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;

    logic             bp_en_q   [NUM_BP];
    logic             bp_en_d   [NUM_BP];
    logic [PC_W-1:0]  bp_addr_q [NUM_BP];
    logic [PC_W-1:0]  bp_addr_d [NUM_BP];

    logic             bp_match;
    logic [IDX_W-1:0] bp_match_idx;
    logic             burst_last;

    // Breakpoint compare against the current slot contents. The loop runs
    // downward so the lowest matching slot is the one left in bp_match_idx.
    // instr_done is not folded in here; the FSM qualifies it.
    always_comb begin
        bp_match     = 1'b0;
        bp_match_idx = '0;
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (bp_en_q[i] && (bp_addr_q[i] == pc)) begin
                bp_match     = 1'b1;
                bp_match_idx = IDX_W'(i);
            end
        end
    end

    // Breakpoint slot writes. Writes to slots past NUM_BP match no index and
    // are dropped. A new value takes effect once it is registered, which is
    // from the following cycle.
    always_comb begin
        bp_en_d   = bp_en_q;
        bp_addr_d = bp_addr_q;
        for (int i = 0; i < NUM_BP; i++) begin
            if (bp_wr && (int'(bp_idx) == i)) begin
                bp_en_d[i]   = bp_en;
                bp_addr_d[i] = bp_addr;
            end
        end
    end

    assign burst_last = (remaining_q == CNT_W'(1));

    // Run-control FSM next state plus the registered status it maintains.
    always_comb begin
        state_d      = state_q;
        halted_bp_d  = halted_bp_q;
        bp_hit_idx_d = bp_hit_idx_q;
        remaining_d  = remaining_q;
        retired_d    = retired_q;

        // Count every retirement while the CPU is enabled. This includes
        // the one that ends a step, a burst or a run on halt_req.
        if ((state_q != ST_HALT) && instr_done) begin
            retired_d = retired_q + CNT_W'(1);
        end

        case (state_q)
            ST_HALT: begin
                if (runCPU) begin
                    state_d     = ST_RUN;
                    halted_bp_d = 1'b0;
                end else if (step_req) begin
                    state_d     = ST_STEP;
                    halted_bp_d = 1'b0;
                end else if (burst_req && (cnt_val != '0)) begin
                    state_d     = ST_BURST;
                    halted_bp_d = 1'b0;
                    remaining_d = cnt_val;
                end
            end

            ST_STEP: begin
                // Breakpoints do not apply here: a step always retires its
                // one instruction.
                if (halt_req || instr_done) begin
                    state_d = ST_HALT;
                end
            end

            ST_RUN: begin
                if (halt_req) begin
                    state_d = ST_HALT;
                end else if (instr_done && bp_match) begin
                    state_d      = ST_HALT;
                    halted_bp_d  = 1'b1;
                    bp_hit_idx_d = bp_match_idx;
                end
            end

            ST_BURST: begin
                if (halt_req) begin
                    state_d = ST_HALT;
                end else if (instr_done) begin
                    remaining_d = remaining_q - CNT_W'(1);
                    // A breakpoint on the last burst instruction still
                    // reports as a breakpoint halt. It is one halt, not two.
                    if (bp_match) begin
                        state_d      = ST_HALT;
                        halted_bp_d  = 1'b1;
                        bp_hit_idx_d = bp_match_idx;
                    end else if (burst_last) begin
                        state_d = ST_HALT;
                    end
                end
            end

            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    // State registers. Reset clears everything, including a burst in
    // progress, and masks all requests and slot writes while it is held.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_HALT;
            halted_bp_q  <= 1'b0;
            bp_hit_idx_q <= '0;
            retired_q    <= '0;
            remaining_q  <= '0;
            for (int i = 0; i < NUM_BP; i++) begin
                bp_en_q[i]   <= 1'b0;
                bp_addr_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            halted_bp_q  <= halted_bp_d;
            bp_hit_idx_q <= bp_hit_idx_d;
            retired_q    <= retired_d;
            remaining_q  <= remaining_d;
            bp_en_q      <= bp_en_d;
            bp_addr_q    <= bp_addr_d;
        end
    end

    assign cpu_en     = (state_q != ST_HALT);
    assign state      = state_q;
    assign halted_bp  = halted_bp_q;
    assign bp_hit_idx = bp_hit_idx_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Testbench for cpu_run_ctrl: directed scenarios with literal expectations,
// plus a behavioural model compared against the DUT on every cycle.
module tb_cpu_run_ctrl;

    localparam int PC_W   = 16;
    localparam int CNT_W  = 8;
    localparam int NUM_BP = 3;
    localparam int IDX_W  = 2;

    localparam int M_HALT  = 0;
    localparam int M_RUN   = 1;
    localparam int M_STEP  = 2;
    localparam int M_BURST = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             runCPU, step_req, burst_req, halt_req, instr_done;
    logic [CNT_W-1:0] cnt_val;
    logic [PC_W-1:0]  pc;
    logic             bp_wr, bp_en;
    logic [IDX_W-1:0] bp_idx;
    logic [PC_W-1:0]  bp_addr;
    logic             cpu_en, halted_bp;
    logic [1:0]       state;
    logic [IDX_W-1:0] bp_hit_idx;
    logic [CNT_W-1:0] retired;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    cpu_run_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W), .NUM_BP(NUM_BP)) dut (
        .clk(clk), .reset(reset), .runCPU(runCPU), .step_req(step_req),
        .burst_req(burst_req), .cnt_val(cnt_val), .halt_req(halt_req),
        .instr_done(instr_done), .pc(pc), .bp_wr(bp_wr), .bp_idx(bp_idx),
        .bp_addr(bp_addr), .bp_en(bp_en), .cpu_en(cpu_en), .state(state),
        .halted_bp(halted_bp), .bp_hit_idx(bp_hit_idx), .retired(retired)
    );

    // Clock
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct {
        int mode;
        int rem;
        int ret;
        int hbp;
        int hidx;
    } mstate_t;

    mstate_t ms;
    int      m_addr [NUM_BP];
    bit      m_en   [NUM_BP];

    function automatic mstate_t model_next(mstate_t s);
        mstate_t n;
        int hit;
        n   = s;
        hit = -1;
        if (!reset) begin
            n.mode = M_HALT; n.rem = 0; n.ret = 0; n.hbp = 0; n.hidx = 0;
            return n;
        end
        if (s.mode != M_HALT && instr_done) n.ret = (s.ret + 1) % (1 << CNT_W);
        for (int i = 0; i < NUM_BP; i++)
            if (hit < 0 && m_en[i] && m_addr[i] == int'(pc)) hit = i;
        if (s.mode == M_HALT) begin
            if (runCPU) begin
                n.mode = M_RUN; n.hbp = 0;
            end else if (step_req) begin
                n.mode = M_STEP; n.hbp = 0;
            end else if (burst_req && cnt_val != 0) begin
                n.mode = M_BURST; n.hbp = 0; n.rem = int'(cnt_val);
            end
        end else if (halt_req) begin
            n.mode = M_HALT;
        end else if (instr_done) begin
            if (s.mode == M_STEP) begin
                n.mode = M_HALT;
            end else begin
                if (s.mode == M_BURST) n.rem = s.rem - 1;
                if (hit >= 0) begin
                    n.mode = M_HALT; n.hbp = 1; n.hidx = hit;
                end else if (s.mode == M_BURST && s.rem == 1) begin
                    n.mode = M_HALT;
                end
            end
        end
        return n;
    endfunction

    always @(posedge clk) begin
        ms <= model_next(ms);
        if (!reset) begin
            for (int i = 0; i < NUM_BP; i++) begin
                m_en[i]   <= 1'b0;
                m_addr[i] <= 0;
            end
        end else if (bp_wr && int'(bp_idx) < NUM_BP) begin
            m_en[bp_idx]   <= bp_en;
            m_addr[bp_idx] <= int'(bp_addr);
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (check_en) begin
            chk("m_state",      32'(state),      32'(ms.mode));
            chk("m_cpu_en",     32'(cpu_en),     32'(ms.mode != M_HALT));
            chk("m_halted_bp",  32'(halted_bp),  32'(ms.hbp));
            chk("m_bp_hit_idx", 32'(bp_hit_idx), 32'(ms.hidx));
            chk("m_retired",    32'(retired),    32'(ms.ret));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle();
        runCPU = 0; step_req = 0; burst_req = 0; halt_req = 0;
        instr_done = 0; cnt_val = '0; pc = '0;
        bp_wr = 0; bp_idx = '0; bp_addr = '0; bp_en = 0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
    endtask

    task automatic write_bp(input int idx, input int addr, input bit en);
        bp_wr = 1; bp_idx = IDX_W'(idx); bp_addr = PC_W'(addr); bp_en = en;
        tick();
        bp_wr = 0;
    endtask

    task automatic retire(input int addr, input int n = 1);
        instr_done = 1; pc = PC_W'(addr);
        tick(n);
        instr_done = 0;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        idle();
        reset = 1'b0;
        tick();
        check_en = 1'b1;
        tick();
        // Reset state
        chk("rst_state", 32'(state), 0);
        chk("rst_cpu_en", 32'(cpu_en), 0);
        chk("rst_retired", 32'(retired), 0);
        chk("rst_halted_bp", 32'(halted_bp), 0);
        chk("rst_hit_idx", 32'(bp_hit_idx), 0);
        reset = 1'b1;

        // Run then halt, one-cycle latency each way
        runCPU = 1; tick(); runCPU = 0;
        chk("run_state", 32'(state), 1);
        chk("run_cpu_en", 32'(cpu_en), 1);
        halt_req = 1; tick(); halt_req = 0;
        chk("halt_state", 32'(state), 0);
        chk("halt_cpu_en", 32'(cpu_en), 0);

        // Single step with three retirements: only the first counts
        do_reset();
        step_req = 1; tick(); step_req = 0;
        chk("step_state", 32'(state), 2);
        retire('h10);
        chk("step_done_state", 32'(state), 0);
        retire('h14, 2);
        chk("step_retired", 32'(retired), 1);

        // Burst of five, then a zero-length burst
        do_reset();
        burst_req = 1; cnt_val = 8'd5; tick(); burst_req = 0;
        chk("burst_state", 32'(state), 3);
        retire('h20, 4);
        chk("burst_mid_state", 32'(state), 3);
        retire('h30);
        chk("burst_end_state", 32'(state), 0);
        chk("burst_retired", 32'(retired), 5);
        chk("burst_halted_bp", 32'(halted_bp), 0);
        burst_req = 1; cnt_val = 8'd0; tick(); burst_req = 0;
        chk("burst0_state", 32'(state), 0);

        // Two slots at 0x40: lowest index wins; ignored in STEP
        do_reset();
        write_bp(0, 'h40, 1);
        write_bp(1, 'h40, 1);
        runCPU = 1; tick(); runCPU = 0;
        retire('h40);
        chk("bp_run_state", 32'(state), 0);
        chk("bp_run_halted", 32'(halted_bp), 1);
        chk("bp_run_idx", 32'(bp_hit_idx), 0);
        step_req = 1; tick(); step_req = 0;
        chk("bp_step_clear", 32'(halted_bp), 0);
        retire('h40);
        chk("bp_step_state", 32'(state), 0);
        chk("bp_step_halted", 32'(halted_bp), 0);
        write_bp(0, 'h40, 0);
        runCPU = 1; tick(); runCPU = 0;
        retire('h40);
        chk("bp_slot1_idx", 32'(bp_hit_idx), 1);

        // Out-of-range slot write ignored; slot write applies next cycle
        write_bp(3, 'h80, 1);
        runCPU = 1; tick(); runCPU = 0;
        retire('h80);
        chk("bp_oob_state", 32'(state), 1);
        bp_wr = 1; bp_idx = 2'd2; bp_addr = 16'h90; bp_en = 1;
        retire('h90);
        bp_wr = 0;
        chk("bp_same_cycle_state", 32'(state), 1);
        retire('h90);
        chk("bp_next_cycle_state", 32'(state), 0);
        chk("bp_next_cycle_idx", 32'(bp_hit_idx), 2);

        // Breakpoint coinciding with the last burst instruction
        burst_req = 1; cnt_val = 8'd3; tick(); burst_req = 0;
        retire('h10, 2);
        chk("coinc_mid_state", 32'(state), 3);
        retire('h40);
        chk("coinc_state", 32'(state), 0);
        chk("coinc_halted", 32'(halted_bp), 1);
        chk("coinc_idx", 32'(bp_hit_idx), 1);

        // Reset mid-burst with runCPU held through it
        do_reset();
        write_bp(0, 'h40, 1);
        burst_req = 1; cnt_val = 8'd4; tick(); burst_req = 0;
        retire('h40 - 4, 2);
        runCPU = 1; instr_done = 1; reset = 1'b0;
        tick(2);
        chk("rst_mid_state", 32'(state), 0);
        chk("rst_mid_retired", 32'(retired), 0);
        runCPU = 0; instr_done = 0; reset = 1'b1;
        tick();
        chk("rst_release_state", 32'(state), 0);
        runCPU = 1; tick(); runCPU = 0;
        retire('h40);
        chk("rst_slots_cleared", 32'(state), 1);
        halt_req = 1; tick(); halt_req = 0;

        // Simultaneous requests: run beats step; halt beats breakpoint
        write_bp(0, 'h40, 1);
        runCPU = 1; step_req = 1; tick(); runCPU = 0; step_req = 0;
        chk("prio_run_state", 32'(state), 1);
        halt_req = 1; retire('h40); halt_req = 0;
        chk("prio_halt_state", 32'(state), 0);
        chk("prio_halt_bp", 32'(halted_bp), 0);
        chk("prio_halt_retired", 32'(retired), 2);

        // retired wraps from all-ones to zero
        do_reset();
        runCPU = 1; tick(); runCPU = 0;
        retire('h0, 260);
        chk("wrap_retired", 32'(retired), 4);
        halt_req = 1; tick(); halt_req = 0;
        retire('h0, 3);
        chk("halt_ignores_done", 32'(retired), 4);

        tick(2);
        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
